// File: rtl/mm_stream_pkg.sv
// Shared types and header field helpers for the matrix-multiplier stream arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mm_stream_pkg;

    localparam logic [15:0] HDR_TAG_DEFAULT = 16'hFF00;

    typedef enum logic [1:0] {
        HOLDOFF = 2'd0,
        IDLE    = 2'd1,
        PASS    = 2'd2
    } arb_state_e;

    // Upper half of a header beat carries the fixed tag.
    function automatic logic [15:0] hdr_tag(input logic [31:0] beat);
        return beat[31:16];
    endfunction

    // Lower half of a header beat carries the payload byte count.
    function automatic logic [15:0] hdr_bytes(input logic [31:0] beat);
        return beat[15:0];
    endfunction

endpackage

// File: rtl/mm_pkt_len_checker.sv
// Counts transferred beats per packet and compares against the header byte count; raises sticky err_o.
// Latency: error visible the cycle after the offending beat transfers.
// Backpressure: observe-only, never stalls the stream.
module mm_pkt_len_checker
    import mm_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        beat_vld_i,
    input  logic        beat_last_i,
    input  logic [31:0] beat_dat_i,
    output logic        err_o
);

    localparam logic [14:0] CNT_SAT = 15'h7FFE;

    logic [14:0] beat_cnt_q, beat_cnt_d;
    logic [14:0] exp_q, exp_d;
    logic        err_q, err_d;

    logic        is_hdr;
    logic [15:0] bytes;
    logic [14:0] exp_now;
    logic [14:0] beat_num;

    assign is_hdr   = (beat_cnt_q == 15'd0);
    assign bytes    = hdr_bytes(beat_dat_i);
    // Header itself is beat 1, so a packet of N payload words is N+1 beats long.
    assign exp_now  = is_hdr ? (15'(bytes[15:2]) + 15'd1) : exp_q;
    assign beat_num = beat_cnt_q + 15'd1;
    assign err_o    = err_q;

    // Next-state: track beat position, latch expected length on the header, flag disagreements.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        exp_d      = exp_q;
        err_d      = err_q;
        if (beat_vld_i) begin
            if (is_hdr) begin
                exp_d = exp_now;
                if (bytes[1:0] != 2'b00) begin
                    err_d = 1'b1;
                end
            end
            if (beat_last_i && (beat_num < exp_now)) begin
                err_d = 1'b1;
            end
            if (!beat_last_i && (beat_num == exp_now)) begin
                err_d = 1'b1;
            end
            // Saturate so an overlong packet cannot wrap back to "header".
            if (beat_last_i) begin
                beat_cnt_d = 15'd0;
            end else if (beat_cnt_q != CNT_SAT) begin
                beat_cnt_d = beat_cnt_q + 15'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= 15'd0;
            exp_q      <= 15'd0;
            err_q      <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: rtl/mm_stream_arbiter.sv
// Packet-atomic round-robin arbiter of two AXI-Stream sources onto the multiplier input; optional length check under MM_ARB_LEN_CHECK_EN.
// Latency: zero-cycle pass-through while granted; one idle bubble per packet for arbitration.
// Backpressure: m_TREADY is routed to the granted source only; the other source sees TREADY=0.
module mm_stream_arbiter
    import mm_stream_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          START_DELAY = 20000,
    parameter logic [15:0] HDR_TAG     = HDR_TAG_DEFAULT,
    parameter int          PKT_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_W-1:0]    s0_TDATA,
    input  logic                 s0_TVALID,
    input  logic                 s0_TLAST,
    output logic                 s0_TREADY,
    input  logic [DATA_W-1:0]    s1_TDATA,
    input  logic                 s1_TVALID,
    input  logic                 s1_TLAST,
    output logic                 s1_TREADY,
    output logic [DATA_W-1:0]    m_TDATA,
    output logic                 m_TVALID,
    output logic                 m_TLAST,
    input  logic                 m_TREADY,
    output logic                 grant_id,
    output logic                 busy,
    output logic                 err_hdr,
    output logic                 err_len,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    localparam int               HOLD_W      = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam arb_state_e       RESET_STATE = (START_DELAY == 0) ? IDLE : HOLDOFF;

    arb_state_e           state_q, state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 grant_q, grant_d;
    logic                 last_q, last_d;      // last source that completed a packet
    logic                 hdr_q, hdr_d;        // next transferred beat is a header
    logic                 err_hdr_q, err_hdr_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic                 in_pass;
    logic                 xfer;

    assign in_pass   = (state_q == PASS);
    assign xfer      = m_TVALID & m_TREADY;
    assign grant_id  = grant_q;
    assign busy      = in_pass;
    assign err_hdr   = err_hdr_q;
    assign pkt_count = pkt_cnt_q;

    // Pass-through mux: only the granted source is visible, everything is zero outside PASS.
    always_comb begin
        m_TVALID  = 1'b0;
        m_TLAST   = 1'b0;
        m_TDATA   = '0;
        s0_TREADY = 1'b0;
        s1_TREADY = 1'b0;
        if (in_pass) begin
            if (grant_q) begin
                m_TVALID  = s1_TVALID;
                m_TLAST   = s1_TLAST;
                m_TDATA   = s1_TDATA;
                s1_TREADY = m_TREADY;
            end else begin
                m_TVALID  = s0_TVALID;
                m_TLAST   = s0_TLAST;
                m_TDATA   = s0_TDATA;
                s0_TREADY = m_TREADY;
            end
        end
    end

    // Next-state: startup holdoff, round-robin grant in IDLE, header check and packet completion in PASS.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hdr_d      = hdr_q;
        err_hdr_d  = err_hdr_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            IDLE: begin
                if (s0_TVALID || s1_TVALID) begin
                    // Contention goes to whoever did not finish the previous packet.
                    grant_d = (s0_TVALID && s1_TVALID) ? ~last_q : s1_TVALID;
                    hdr_d   = 1'b1;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (xfer) begin
                    hdr_d = 1'b0;
                    if (hdr_q && (hdr_tag(m_TDATA[31:0]) != HDR_TAG)) begin
                        err_hdr_d = 1'b1;
                    end
                    if (m_TLAST) begin
                        pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
                        last_d    = grant_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State registers; last_q starts at 1 so source 0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            hold_cnt_q <= '0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            hdr_q      <= 1'b1;
            err_hdr_q  <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hdr_q      <= hdr_d;
            err_hdr_q  <= err_hdr_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

`ifdef MM_ARB_LEN_CHECK_EN
    mm_pkt_len_checker u_len_chk (
        .clk         (clk),
        .rst_n       (reset_n),
        .beat_vld_i  (xfer),
        .beat_last_i (m_TLAST),
        .beat_dat_i  (m_TDATA[31:0]),
        .err_o       (err_len)
    );
`else
    assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_mm_stream_arbiter.sv
// Scoreboard bench for mm_stream_arbiter: expected beats queued at stimulus time, monitor pops on every m_* transfer.
// Latency: holdoff of 16 cycles plus one arbitration bubble checked explicitly.
// Backpressure: exercised with an alternating m_TREADY pattern.
module tb_mm_stream_arbiter;

    localparam int DW = 32;
    localparam int SD = 16;

`ifdef MM_ARB_LEN_CHECK_EN
    localparam logic LEN_EXP = 1'b1;
`else
    localparam logic LEN_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] s0_TDATA, s1_TDATA, m_TDATA;
    logic          s0_TVALID, s0_TLAST, s0_TREADY;
    logic          s1_TVALID, s1_TLAST, s1_TREADY;
    logic          m_TVALID, m_TLAST, m_TREADY;
    logic          grant_id, busy, err_hdr, err_len;
    logic [15:0]   pkt_count;
    logic          tog_en = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        g;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    mm_stream_arbiter #(
        .DATA_W      (DW),
        .START_DELAY (SD),
        .HDR_TAG     (16'hFF00),
        .PKT_CNT_W   (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s0_TDATA  (s0_TDATA),
        .s0_TVALID (s0_TVALID),
        .s0_TLAST  (s0_TLAST),
        .s0_TREADY (s0_TREADY),
        .s1_TDATA  (s1_TDATA),
        .s1_TVALID (s1_TVALID),
        .s1_TLAST  (s1_TLAST),
        .s1_TREADY (s1_TREADY),
        .m_TDATA   (m_TDATA),
        .m_TVALID  (m_TVALID),
        .m_TLAST   (m_TLAST),
        .m_TREADY  (m_TREADY),
        .grant_id  (grant_id),
        .busy      (busy),
        .err_hdr   (err_hdr),
        .err_len   (err_len),
        .pkt_count (pkt_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Sink ready: held high, or alternating 1,0,1,0 when tog_en is set.
    initial begin
        m_TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_TREADY = tog_en ? ~m_TREADY : 1'b1;
        end
    end

    // Monitor: every transferred output beat must be the next expected one.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && m_TVALID === 1'b1 && m_TREADY === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: actual %0h required no beat", m_TDATA);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", m_TDATA, e.d);
                chk("beat_last", 32'(m_TLAST), 32'(e.l));
                chk("beat_grant", 32'(grant_id), 32'(e.g));
            end
        end
    end

    task automatic push_pkt(input logic g, input logic [31:0] hdr, input int nw,
                            input logic [31:0] base, input logic [31:0] step, input bit trunc);
        beat_t b;
        for (int i = 0; i <= nw; i++) begin
            b.d = (i == 0) ? hdr : base + step * 32'(i - 1);
            b.l = (i == nw) && !trunc;
            b.g = g;
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_beat(input logic src, input logic [31:0] d, input logic l, output bit ok);
        int waited;
        bit acc;
        waited = 0;
        acc    = 1'b0;
        ok     = 1'b1;
        if (src) begin
            s1_TDATA = d; s1_TLAST = l; s1_TVALID = 1'b1;
        end else begin
            s0_TDATA = d; s0_TLAST = l; s0_TVALID = 1'b1;
        end
        while (!acc) begin
            @(negedge clk);
            acc = src ? s1_TREADY : s0_TREADY;
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited >= 5000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: src %0d not accepted after %0d cycles, required acceptance", src, waited);
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic send_pkt(input logic src, input logic [31:0] hdr, input int nw,
                            input logic [31:0] base, input logic [31:0] step, input bit trunc);
        bit ok;
        logic [31:0] d;
        for (int i = 0; i <= nw; i++) begin
            d = (i == 0) ? hdr : base + step * 32'(i - 1);
            drive_beat(src, d, (i == nw) && !trunc, ok);
            if (!ok) break;
        end
        if (src) begin
            s1_TVALID = 1'b0; s1_TLAST = 1'b0;
        end else begin
            s0_TVALID = 1'b0; s0_TLAST = 1'b0;
        end
    endtask

    // 16 holdoff cycles plus the arbitration bubble, then the header of a packet from s0.
    task automatic holdoff_check(input logic [31:0] hdr);
        for (int i = 0; i < SD + 1; i++) begin
            @(negedge clk);
            chk("holdoff_m_tvalid", 32'(m_TVALID), 32'd0);
            chk("holdoff_s0_tready", 32'(s0_TREADY), 32'd0);
        end
        @(negedge clk);
        chk("first_hdr_valid", 32'(m_TVALID), 32'd1);
        chk("first_hdr_data", m_TDATA, hdr);
        chk("first_hdr_busy", 32'(busy), 32'd1);
        chk("first_hdr_grant", 32'(grant_id), 32'd0);
    endtask

    task automatic zero_outputs_check();
        chk("rst_m_tvalid", 32'(m_TVALID), 32'd0);
        chk("rst_m_tlast", 32'(m_TLAST), 32'd0);
        chk("rst_m_tdata", m_TDATA, 32'd0);
        chk("rst_s0_tready", 32'(s0_TREADY), 32'd0);
        chk("rst_s1_tready", 32'(s1_TREADY), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_hdr", 32'(err_hdr), 32'd0);
        chk("rst_err_len", 32'(err_len), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        s0_TDATA  = '0; s0_TVALID = 1'b0; s0_TLAST = 1'b0;
        s1_TDATA  = '0; s1_TVALID = 1'b0; s1_TLAST = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        zero_outputs_check();

        // A: s0 valid from release; holdoff, bubble, then 1765-beat packet.
        push_pkt(1'b0, 32'hFF001B90, 1764, 32'h1, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fork
            send_pkt(1'b0, 32'hFF001B90, 1764, 32'h1, 32'h0, 1'b0);
            holdoff_check(32'hFF001B90);
        join
        @(negedge clk);
        chk("A_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("A_pkt_count", 32'(pkt_count), 32'd1);
        chk("A_err_hdr", 32'(err_hdr), 32'd0);
        chk("A_err_len", 32'(err_len), 32'd0);
        chk("A_busy_idle", 32'(busy), 32'd0);

        // B: s1 alone with a bad tag; forwarded unchanged, err_hdr sticks.
        push_pkt(1'b1, 32'hAB001B90, 1764, 32'h1000, 32'h1, 1'b0);
        send_pkt(1'b1, 32'hAB001B90, 1764, 32'h1000, 32'h1, 1'b0);
        @(negedge clk);
        chk("B_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("B_pkt_count", 32'(pkt_count), 32'd2);
        chk("B_err_hdr", 32'(err_hdr), 32'd1);
        chk("B_err_len", 32'(err_len), 32'd0);
        chk("B_grant_id", 32'(grant_id), 32'd1);

        // C: both sources together; s1 finished last, so s0 goes first, no interleave.
        push_pkt(1'b0, 32'hFF0001F8, 126, 32'h2000, 32'h1, 1'b0);
        push_pkt(1'b1, 32'hFF0001F8, 126, 32'h3000, 32'h1, 1'b0);
        fork
            send_pkt(1'b0, 32'hFF0001F8, 126, 32'h2000, 32'h1, 1'b0);
            send_pkt(1'b1, 32'hFF0001F8, 126, 32'h3000, 32'h1, 1'b0);
        join
        @(negedge clk);
        chk("C_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("C_pkt_count", 32'(pkt_count), 32'd4);
        chk("C_grant_id", 32'(grant_id), 32'd1);

        // D: sink ready alternating during a 127-beat packet.
        tog_en = 1'b1;
        push_pkt(1'b0, 32'hFF0001F8, 126, 32'h4000, 32'h1, 1'b0);
        send_pkt(1'b0, 32'hFF0001F8, 126, 32'h4000, 32'h1, 1'b0);
        tog_en = 1'b0;
        @(negedge clk);
        chk("D_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("D_pkt_count", 32'(pkt_count), 32'd5);
        chk("D_grant_id", 32'(grant_id), 32'd0);

        // E: header says 16 bytes (5 beats) but TLAST arrives on beat 3.
        push_pkt(1'b0, 32'hFF000010, 2, 32'h5000, 32'h1, 1'b0);
        send_pkt(1'b0, 32'hFF000010, 2, 32'h5000, 32'h1, 1'b0);
        @(negedge clk);
        chk("E_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("E_pkt_count", 32'(pkt_count), 32'd6);
        chk("E_err_len", 32'(err_len), 32'(LEN_EXP));

        // F: reset while payload beat 50 is presented.
        push_pkt(1'b0, 32'hFF0001F8, 49, 32'h6000, 32'h1, 1'b1);
        send_pkt(1'b0, 32'hFF0001F8, 49, 32'h6000, 32'h1, 1'b1);
        chk("F_busy_mid", 32'(busy), 32'd1);
        s0_TDATA  = 32'h6000 + 32'd49;
        s0_TVALID = 1'b1;
        #1;
        chk("F_beat50_valid", 32'(m_TVALID), 32'd1);
        chk("F_beat50_data", m_TDATA, 32'h6031);
        #1;
        reset_n = 1'b0;
        #1;
        zero_outputs_check();
        chk("F_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        s0_TVALID = 1'b0;
        repeat (2) @(posedge clk);

        // G: holdoff repeats after release; single-beat packet completes from zeroed counters.
        push_pkt(1'b0, 32'hFF000000, 0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fork
            send_pkt(1'b0, 32'hFF000000, 0, 32'h0, 32'h0, 1'b0);
            holdoff_check(32'hFF000000);
        join
        @(negedge clk);
        chk("G_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("G_pkt_count", 32'(pkt_count), 32'd1);
        chk("G_err_hdr", 32'(err_hdr), 32'd0);
        chk("G_err_len", 32'(err_len), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
